// File: rtl/btn_pkg.sv
// Shared types and helpers for the pushbutton conditioning channels.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    // Number of clock cycles that make up one debounce window.
    function automatic int db_cycles(input int fpga_f, input int db_ms);
        return fpga_f / 1000 * db_ms;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM, toggled level and press strobe.
module debounce_ch
    import btn_pkg::*;
#(
    parameter int   DB_CYCLES = 8,
    parameter logic INIT      = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic nbtn,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    db_state_t     state;

    assign s = sync[1];

    // Synchroniser idles at 1 so a reset looks like a released button.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], nbtn};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= INIT;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state <= PRESSED;
                        level <= ~level;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A low during the release window is bounce, not a new press.
                    if (!s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the rate-select and direction pushbuttons into toggled levels with press strobes.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int   fpga_f    = 50_000_000,
    parameter int   db_ms     = 10,
    parameter logic TIME_INIT = 1'b0,
    parameter logic UP_INIT   = 1'b1
) (
    input  logic clk,
    input  logic nreset,
    input  logic nbtn_time,
    input  logic nbtn_dir,
    output logic timeS,
    output logic up,
    output logic time_pulse,
    output logic dir_pulse
);

    localparam int DB_CYCLES = db_cycles(fpga_f, db_ms);

    debounce_ch #(
        .DB_CYCLES(DB_CYCLES),
        .INIT     (TIME_INIT)
    ) u_time_ch (
        .clk   (clk),
        .nreset(nreset),
        .nbtn  (nbtn_time),
        .level (timeS),
        .pulse (time_pulse)
    );

    debounce_ch #(
        .DB_CYCLES(DB_CYCLES),
        .INIT     (UP_INIT)
    ) u_dir_ch (
        .clk   (clk),
        .nreset(nreset),
        .nbtn  (nbtn_dir),
        .level (up),
        .pulse (dir_pulse)
    );

endmodule
